// File: rtl/fwuart_rx_if.sv
// fwuart_rx_if: ready/valid byte delivery port of the UART receiver
interface fwuart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] i_dat;
    logic                 i_valid;
    logic                 i_ready;
    modport master (output i_dat, output i_valid, input i_ready);
    modport slave  (input i_dat, input i_valid, output i_ready);
endinterface

// File: rtl/fwuart_rx.sv
// fwuart_rx: 16x oversampled UART receiver, 1 start / DATA_BITS data (LSB first) / 1 stop,
// one-entry holding register on a ready/valid port, framing-error and overrun pulses.
// Optional FWUART_RX_MAJORITY_EN: bit value is a 2-of-3 vote over cnt 6..8 instead of one cnt 7 sample.
module fwuart_rx #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clock_x16,
    input  logic        rx,
    fwuart_rx_if.master i_port,
    output logic        frame_err,
    output logic        overrun
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t               state, state_nxt;
    logic [3:0]           cnt, cnt_nxt;
    logic [2:0]           bit_idx, bit_idx_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 armed, armed_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                 rxs, smp, bit_val, done, bad, stall;

    assign rxs   = sync[SYNC_STAGES-1];
    assign stall = i_port.i_valid && !i_port.i_ready;

    // metastability synchroniser on the rx line, idle-high out of reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) sync <= '1;
        else        sync <= {sync[SYNC_STAGES-2:0], rx};
    end

`ifdef FWUART_RX_MAJORITY_EN
    logic [1:0] votes;
    // capture the two early votes at cnt 6 and 7; the third vote is live rxs at cnt 8
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) votes <= '0;
        else if (clock_x16 && state != IDLE && cnt == 4'd6) votes[0] <= rxs;
        else if (clock_x16 && state != IDLE && cnt == 4'd7) votes[1] <= rxs;
    end
    assign smp     = clock_x16 && cnt == 4'd8;
    assign bit_val = (votes[0] & votes[1]) | (votes[0] & rxs) | (votes[1] & rxs);
`else
    assign smp     = clock_x16 && cnt == 4'd7;
    assign bit_val = rxs;
`endif

    // frame state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            armed   <= 1'b1;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shreg   <= shreg_nxt;
            armed   <= armed_nxt;
        end
    end

    // deframing: advances only on x16 ticks; stop sample returns to IDLE early for resync margin
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        armed_nxt   = armed;
        done        = 1'b0;
        bad         = 1'b0;
        if (clock_x16) begin
            cnt_nxt = cnt + 4'd1;
            if (rxs) armed_nxt = 1'b1;
            case (state)
                IDLE: begin
                    cnt_nxt = '0;
                    if (!rxs && armed) state_nxt = START;
                end
                START: begin
                    if (smp && bit_val) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == 4'd15) begin
                        state_nxt   = DATA;
                        bit_idx_nxt = '0;
                    end
                end
                DATA: begin
                    if (smp) shreg_nxt = {bit_val, shreg[DATA_BITS-1:1]};
                    if (cnt == 4'd15) begin
                        if (bit_idx == 3'(DATA_BITS-1)) state_nxt = STOP;
                        else bit_idx_nxt = bit_idx + 3'd1;
                    end
                end
                default: begin
                    if (smp) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        done      = bit_val;
                        bad       = !bit_val;
                        if (!bit_val) armed_nxt = 1'b0;
                    end
                end
            endcase
        end
    end

    // holding register and error pulses; a completed byte is dropped only if a held byte is stalled
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            i_port.i_dat   <= '0;
            i_port.i_valid <= 1'b0;
            frame_err      <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            frame_err <= bad;
            overrun   <= done && stall;
            if (done && !stall) begin
                i_port.i_dat   <= shreg;
                i_port.i_valid <= 1'b1;
            end else if (i_port.i_valid && i_port.i_ready) begin
                i_port.i_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fwuart_rx.sv
// tb_fwuart_rx: directed frames against a byte-queue model of the receiver
module tb_fwuart_rx;
    localparam int DB = 8;
    logic clock = 1'b0, reset = 1'b0, clock_x16 = 1'b0, rx = 1'b1;
    logic frame_err, overrun;
    int errors = 0, checks = 0;
    int div = 0;
    logic [DB-1:0] exp_q[$];
    int exp_fe = 0, exp_ov = 0, fe_cnt = 0, ov_cnt = 0, got_cnt = 0;
    logic [DB-1:0] last_dat = '0, prev_dat = '0;
    logic prev_hold = 1'b0;

    fwuart_rx_if #(.DATA_BITS(DB)) bus ();

    fwuart_rx #(.DATA_BITS(DB), .SYNC_STAGES(2)) dut (
        .clock(clock), .reset(reset), .clock_x16(clock_x16), .rx(rx),
        .i_port(bus), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        div = (div + 1) % 4;
        clock_x16 = (div == 0);
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    always @(negedge clock) begin
        if (!reset) prev_hold = 1'b0;
        else begin
            if (prev_hold) chk("hold_stable", 32'(bus.i_dat), 32'(prev_dat));
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (bus.i_valid && bus.i_ready) begin
                if (exp_q.size() == 0) chk("unexpected_byte", 32'(bus.i_dat), 32'hDEAD);
                else chk("byte", 32'(bus.i_dat), 32'(exp_q.pop_front()));
                got_cnt++;
                last_dat = bus.i_dat;
            end
            prev_hold = bus.i_valid && !bus.i_ready;
            prev_dat  = bus.i_dat;
        end
    end

    task automatic wait_tick();
        do @(posedge clock); while (!clock_x16);
        #1;
    endtask

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) wait_tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch_bit);
        drive(1'b0, 16);
        for (int i = 0; i < DB; i++) begin
            if (i == glitch_bit) begin
                drive(d[i], 8);
                drive(!d[i], 1);
                drive(d[i], 7);
            end else drive(d[i], 16);
        end
        if (!stop) exp_fe++;
        else if (exp_q.size() > 0) exp_ov++;
        else exp_q.push_back(d);
        drive(stop, 16);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        int g;
        bus.i_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_valid", 32'(bus.i_valid), 0);
        chk("rst_dat", 32'(bus.i_dat), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_overrun", 32'(overrun), 0);
        reset = 1'b1;
        drive(1'b1, 20);
        send_frame(8'hA5, 1'b1, -1);
        drive(1'b1, 16);
        chk("t1_byte", 32'(last_dat), 32'hA5);
        chk("t1_count", 32'(got_cnt), 1);
        chk("t1_errs", 32'(fe_cnt + ov_cnt), 0);
        g = got_cnt;
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        send_frame(8'h55, 1'b1, -1);
        drive(1'b1, 16);
        chk("t2_count", 32'(got_cnt - g), 3);
        chk("t2_last", 32'(last_dat), 32'h55);
        g = got_cnt;
        drive(1'b0, 4);
        drive(1'b1, 32);
        chk("t3_glitch_nobyte", 32'(got_cnt - g), 0);
        send_frame(8'h3C, 1'b1, -1);
        drive(1'b1, 16);
        chk("t3_byte", 32'(last_dat), 32'h3C);
        g = got_cnt;
        send_frame(8'h81, 1'b0, -1);
        drive(1'b1, 32);
        chk("t4_frame_err", 32'(fe_cnt), 1);
        chk("t4_nobyte", 32'(got_cnt - g), 0);
        send_frame(8'h42, 1'b1, -1);
        drive(1'b1, 16);
        chk("t4_byte", 32'(last_dat), 32'h42);
        @(posedge clock);
        #1;
        bus.i_ready = 1'b0;
        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h22, 1'b1, -1);
        drive(1'b1, 16);
        chk("t5_valid_held", 32'(bus.i_valid), 1);
        chk("t5_dat_held", 32'(bus.i_dat), 32'h11);
        chk("t5_overrun", 32'(ov_cnt), 1);
        bus.i_ready = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        chk("t5_consumed", 32'(last_dat), 32'h11);
        chk("t5_valid_low", 32'(bus.i_valid), 0);
        g = got_cnt;
        drive(1'b0, 16);
        drive(1'b0, 48);
        drive(1'b0, 6);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("t6_rst_valid", 32'(bus.i_valid), 0);
        chk("t6_rst_dat", 32'(bus.i_dat), 0);
        rx = 1'b1;
        reset = 1'b1;
        drive(1'b1, 20);
        send_frame(8'h0F, 1'b1, -1);
        drive(1'b1, 16);
        chk("t6_count", 32'(got_cnt - g), 1);
        chk("t6_byte", 32'(last_dat), 32'h0F);
`ifdef FWUART_RX_MAJORITY_EN
        send_frame(8'h00, 1'b1, 2);
        drive(1'b1, 16);
        chk("t6_majority", 32'(last_dat), 32'h00);
`endif
        drive(1'b1, 16);
        chk("total_frame_err", 32'(fe_cnt), 32'(exp_fe));
        chk("total_overrun", 32'(ov_cnt), 32'(exp_ov));
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
